uart_rx_param: RTL

//  Parametrised UART receiver: FSM, bit/clock counters and data path in one block.

---
 rtl/uart_rx_param.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with input synchroniser, false-start
// rejection, framing/overrun detection and a valid/ready output buffer.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             STP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CNT_W-1:0]     clk_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 stop_bad;
    logic                 done;
    logic                 armed;
    logic                 par_bad_c;

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    // Received parity bit against the expected even/odd parity of the data word
    assign par_bad_c = ((^shift_q) ^ 1'(PARITY_ODD)) != par_bit;
`else
    logic unused_parity_odd;

    assign par_bad_c         = 1'b0;
    assign unused_parity_odd = 1'(PARITY_ODD);
`endif

    // Two-flop synchroniser for the asynchronous serial line (idle high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM: start validation, bit-centre sampling, stop check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            shift_q  <= '0;
            stop_bad <= 1'b0;
            done     <= 1'b0;
            armed    <= 1'b1;
            busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    if (rx_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state <= S_START;
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_LAST) begin
                            stop_cnt <= 1'b0;
                            stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            state    <= S_PARITY;
`else
                            state    <= S_STOP;
`endif
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        par_bit <= rx_s;
                        state   <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            stop_bad <= 1'b1;
                        end
                        if (stop_cnt == STP_LAST) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            // A line still low at the last stop must go high before re-arming
                            armed <= rx_s;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output buffer: frame completion, error pulses and valid/ready handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            parity_err  <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (done) begin
                if (stop_bad || par_bad_c) begin
                    frame_err  <= stop_bad;
                    parity_err <= par_bad_c;
                end else if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_q;
                    rx_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end
        end
    end

endmodule
